// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types: cache line, icache state, line geometry
package lc3b_types;

  localparam int LC3B_LINE_OFFSET_BITS = 4;

  typedef logic [127:0] lc3b_line;

  typedef enum logic {IC_IDLE, IC_FILL} lc3b_icache_state_t;

  // Word w of a line lives at bits [16w+15:16w].
  function automatic logic [15:0] line_word(input lc3b_line line, input logic [2:0] off);
    return line[{off, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped valid/tag/data storage, async read, sync write
module icache_array
  import lc3b_types::*;
#(
  parameter int IDX_BITS = 3,
  parameter int TAG_W    = 16 - LC3B_LINE_OFFSET_BITS - IDX_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output lc3b_line            rd_line,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]    wr_tag,
  input  lc3b_line            wr_line
);

  localparam int SETS = 1 << IDX_BITS;

  logic [SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [SETS];
  lc3b_line         data_q [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/icache_ro.sv
// rtl/icache_ro.sv - read-only direct-mapped instruction cache with zero-wait hits
module icache_ro
  import lc3b_types::*;
#(
  parameter int IDX_BITS = 3,
  parameter bit SAT_CNT  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int OFF   = LC3B_LINE_OFFSET_BITS;
  localparam int TAG_W = 16 - OFF - IDX_BITS;

  lc3b_icache_state_t state, next_state;
  logic [15:0]        fill_addr;
  logic               hit, fill_start, arr_we;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  lc3b_line           rd_line;

  logic [IDX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                unused_inputs;

  assign req_idx       = mem_address[OFF+IDX_BITS-1:OFF];
  assign req_tag       = mem_address[15:OFF+IDX_BITS];
  assign unused_inputs = ^{mem_write, mem_byte_enable, mem_wdata, mem_address[0]};

  icache_array #(.IDX_BITS(IDX_BITS), .TAG_W(TAG_W)) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (req_idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_line (rd_line),
    .wr_en   (arr_we),
    .wr_idx  (fill_addr[OFF+IDX_BITS-1:OFF]),
    .wr_tag  (fill_addr[15:OFF+IDX_BITS]),
    .wr_line (pmem_rdata)
  );

  assign hit = rd_valid && (rd_tag == req_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IC_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    fill_start = 1'b0;
    case (state)
      IC_IDLE: if (mem_read && !hit) begin
        next_state = IC_FILL;
        fill_start = 1'b1;
      end
      IC_FILL: if (pmem_resp) next_state = IC_IDLE;
      default: next_state = IC_IDLE;
    endcase
  end

  always_comb begin
    mem_resp  = 1'b0;
    mem_rdata = 16'h0000;
    arr_we    = 1'b0;
    if (state == IC_IDLE && mem_read && hit) begin
      mem_resp  = 1'b1;
      mem_rdata = line_word(rd_line, mem_address[3:1]);
    end
    // A fill only lands while in FILL; a stray pmem_resp in IDLE is dropped.
    if (state == IC_FILL && pmem_resp) arr_we = 1'b1;
  end

  // pmem_read is the registered state bit, so reset drops it without a clock edge.
  assign pmem_read    = (state == IC_FILL);
  assign pmem_address = fill_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          fill_addr <= 16'h0000;
    else if (fill_start) fill_addr <= {mem_address[15:OFF], {OFF{1'b0}}};
  end

  function automatic logic [15:0] cnt_inc(input logic [15:0] c);
    return (SAT_CNT && c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      if (mem_resp)   hit_count  <= cnt_inc(hit_count);
      if (fill_start) miss_count <= cnt_inc(miss_count);
    end
  end

endmodule

// File: tb/tb_icache_ro.sv
// tb/tb_icache_ro.sv - directed self-checking bench for icache_ro
module tb_icache_ro;

  logic         clk;
  logic         rst_n;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  logic         mem_resp, pmem_read;
  logic [15:0]  mem_rdata, pmem_address, hit_count, miss_count;
  logic         w_mem_resp, w_pmem_read;
  logic [15:0]  w_mem_rdata, w_pmem_address, w_hit_count, w_miss_count;

  int total = 0;
  int bad   = 0;

  icache_ro #(.IDX_BITS(3), .SAT_CNT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  icache_ro #(.IDX_BITS(3), .SAT_CNT(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_resp(w_mem_resp), .mem_rdata(w_mem_rdata), .pmem_address(w_pmem_address),
    .pmem_read(w_pmem_read), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(w_hit_count), .miss_count(w_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic        exp_resp;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] line_from(input logic [15:0] base);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[16*w +: 16] = base + 16'(w);
    return l;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Miss with pmem answering in the lat-th cycle of FILL; response expected one cycle later.
  task automatic do_miss(input logic [15:0] addr, input logic [127:0] line,
                         input logic [15:0] exp_word, input int lat);
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; mem_address = addr; pmem_rdata = line;
    #1 chk("miss_no_resp", mem_resp, 0);
    @(posedge clk); #1;
    chk("fill_pmem_read", pmem_read, 1);
    chk("fill_pmem_addr", pmem_address, {addr[15:4], 4'h0});
    repeat (lat - 1) begin
      @(posedge clk); #1;
      chk("fill_hold_read", pmem_read, 1);
      chk("fill_no_resp", mem_resp, 0);
    end
    pmem_resp = 1'b1;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    #1;
    chk("post_fill_pmem_read", pmem_read, 0);
    chk("post_fill_resp", mem_resp, 1);
    chk("post_fill_rdata", mem_rdata, exp_word);
  endtask

  initial begin
    int exp_hits;
    vecs[0]  = '{1'b1, 1'b0, 16'h0002, 1'b1, 16'h0001};
    vecs[1]  = '{1'b1, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vecs[2]  = '{1'b1, 1'b0, 16'h0006, 1'b1, 16'h0003};
    vecs[3]  = '{1'b1, 1'b0, 16'h0008, 1'b1, 16'h0004};
    vecs[4]  = '{1'b1, 1'b0, 16'h000A, 1'b1, 16'h0005};
    vecs[5]  = '{1'b1, 1'b0, 16'h000C, 1'b1, 16'h0006};
    vecs[6]  = '{1'b1, 1'b0, 16'h000E, 1'b1, 16'h0007};
    vecs[7]  = '{1'b0, 1'b0, 16'h0004, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h0003};
    vecs[10] = '{1'b1, 1'b0, 16'h0009, 1'b1, 16'h0004};

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_address = 16'h0000;
    mem_byte_enable = 2'b11; mem_wdata = 16'hDEAD; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 mem_read = 1'b1;
    #1;
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_addr", pmem_address, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    mem_read = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    do_miss(16'h0000, line_from(16'h0000), 16'h0000, 3);
    chk("first_miss_count", miss_count, 1);

    exp_hits = 1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      mem_read = vecs[i].rd; mem_write = vecs[i].wr; mem_address = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d_resp", i), mem_resp, vecs[i].exp_resp);
      chk($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_pmem_read", i), pmem_read, 0);
      if (vecs[i].exp_resp) exp_hits++;
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    #1 chk("table_hit_count", hit_count, exp_hits);

    do_reset();
    do_miss(16'h0000, line_from(16'h0000), 16'h0000, 3);
    do_miss(16'h0080, line_from(16'h0800), 16'h0800, 2);
    do_miss(16'h0000, line_from(16'h5500), 16'h5500, 4);
    #1 chk("conflict_miss_count", miss_count, 3);

    @(posedge clk); #1;
    mem_read = 1'b1; mem_address = 16'h0130; pmem_rdata = line_from(16'h7700);
    @(posedge clk); #1 chk("midfill_pmem_read", pmem_read, 1);
    @(posedge clk); #1;
    rst_n = 1'b0; mem_read = 1'b0;
    #1;
    chk("midfill_rst_drop", pmem_read, 0);
    chk("midfill_rst_miss_count", miss_count, 0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    pmem_resp = 1'b1; pmem_rdata = line_from(16'hBAD0);
    @(posedge clk); #1 pmem_resp = 1'b0;
    do_miss(16'h0130, line_from(16'h1300), 16'h1300, 3);
    chk("refetch_miss_count", miss_count, 1);
    do_miss(16'h0000, line_from(16'h2200), 16'h2200, 1);

    @(posedge clk); #1;
    mem_read = 1'b1; mem_address = 16'h0040; pmem_rdata = line_from(16'h4400);
    #1 chk("abandon_miss_resp", mem_resp, 0);
    @(posedge clk); #1;
    mem_address = 16'h0050; mem_read = 1'b0;
    #1;
    chk("abandon_fill_addr", pmem_address, 16'h0040);
    chk("abandon_fill_resp", mem_resp, 0);
    @(posedge clk); #1 pmem_resp = 1'b1;
    #1 chk("abandon_resp_cycle", mem_resp, 0);
    @(posedge clk); #1 pmem_resp = 1'b0;
    #1;
    chk("abandon_after_resp", mem_resp, 0);
    chk("abandon_pmem_read", pmem_read, 0);
    @(posedge clk); #1;
    mem_read = 1'b1; mem_address = 16'h0040;
    #1;
    chk("abandon_later_hit", mem_resp, 1);
    chk("abandon_later_rdata", mem_rdata, 16'h4400);
    chk("abandon_miss_count", miss_count, 3);

    do_reset();
    do_miss(16'h0000, line_from(16'h0000), 16'h0000, 3);
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_at_ffff", hit_count, 16'hFFFF);
    chk("wrap_at_ffff", w_hit_count, 16'hFFFF);
    @(posedge clk); #1;
    mem_read = 1'b0;
    #1;
    chk("sat_hold", hit_count, 16'hFFFF);
    chk("wrap_to_zero", w_hit_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_ro.md
Name: icache_ro

Overview:
- Read-only, direct-mapped instruction cache between the CPU fetch port and the physical memory port.
- Consumes the fetch-stage request: address = current PC, read permanently high, write permanently low.
- Returns a 16-bit instruction word. Its response pulse is the fetch stage's PC/IF-ID load enable.
- On a miss it fills a 128-bit line from physical memory, then serves the request as a hit.

Parameters:
- IDX_BITS, 3, log2 of the number of sets (default 8 sets). Tag width = 16 - 4 - IDX_BITS.
- SAT_CNT, 1, 1 = hit/miss counters saturate at 0xFFFF; 0 = counters wrap.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_address  in  16  fetch byte address. Bit 0 is ignored.
- mem_read  in  1  fetch request.
- mem_write  in  1  unsupported; ignored.
- mem_byte_enable  in  2  ignored; full word always returned.
- mem_wdata  in  16  ignored.
- mem_resp  out  1  fetch word valid this cycle.
- mem_rdata  out  16  fetch word.
- pmem_address  out  16  line-aligned fill address, bits [3:0] = 0.
- pmem_read  out  1  fill request.
- pmem_rdata  in  128  fill line; word w occupies bits [16w+15:16w].
- pmem_resp  in  1  fill data valid, one-cycle pulse.
- hit_count  out  16  responses served.
- miss_count  out  16  fills started.

Behaviour:
- Address split:
  - offset = mem_address[3:1] (word select).
  - index = mem_address[3+IDX_BITS:4].
  - tag = mem_address[15:4+IDX_BITS].
- Storage per set: valid bit, tag, 128-bit data line. No dirty bits; no writes from the CPU side.
- Reset (async, rst_n low), all values hold while reset is asserted:
  - All valid bits cleared; state = IDLE.
  - mem_resp = 0, mem_rdata = 0.
  - pmem_read = 0, pmem_address = 0.
  - hit_count = 0, miss_count = 0.
  - Data and tag arrays need not reset.
- hit = valid[index] & (tag_array[index] == tag).
- State IDLE:
  - mem_read & hit: mem_resp = 1 combinationally in the same cycle (zero-wait hit); mem_rdata = line[index] word offset.
  - mem_read & !hit: mem_resp = 0; next state FILL; latch line-aligned address into fill_addr; miss_count += 1.
  - !mem_read: mem_resp = 0, no state change. mem_rdata is don't-care whenever mem_resp = 0; drive 0.
- State FILL:
  - pmem_read = 1 and pmem_address = fill_addr, both registered and stable for the whole state.
  - mem_resp = 0 every cycle of FILL.
  - On pmem_resp: write pmem_rdata into the data line, the tag into the tag array, and set valid at fill_addr's index. Next state IDLE.
  - pmem_read drops on the cycle after pmem_resp.
  - If the requester re-presents the same address, the access is a hit one cycle after pmem_resp. Miss-to-response latency = pmem latency + 1.
- Boundary conditions:
  - mem_read deasserts or mem_address changes during FILL: the fill still completes into fill_addr's set. No response is generated for the abandoned address.
  - pmem_resp while in IDLE: ignored; no array write.
  - Conflict miss (same index, different tag): overwrite the set unconditionally; no writeback.
  - rst_n asserted mid-FILL: pmem_read drops immediately (asynchronous) and the partial fill is discarded. A pmem_resp arriving after reset release is ignored.
  - mem_write = 1: treated as no request. mem_resp = 0 unless mem_read is also high, in which case the access is handled as a read.
- Counters:
  - hit_count += 1 on each cycle with mem_resp = 1.
  - miss_count += 1 on each IDLE->FILL transition.
  - With SAT_CNT = 1 the counters hold at 0xFFFF.

Decomposition:
- lc3b_types (shared package) gains:
  - lc3b_line, a 128-bit typedef.
  - lc3b_icache_state_t enum {IC_IDLE, IC_FILL}.
  - Constant LC3B_LINE_OFFSET_BITS = 4.
- Sub-module icache_array:
  - Holds the valid/tag/data arrays, parameterised by IDX_BITS.
  - Async-read, synchronous-write.
  - Valid bits async-cleared by rst_n.
- Top level holds the FSM, fill_addr register, hit compare, word select mux and counters.

Test Plan:
- Reset, then mem_read = 1 at 0x0000 with pmem_rdata = 0x0007_0006_..._0000:
  - One cycle later, pmem_read = 1 with pmem_address = 0x0000.
  - pmem_resp after 3 cycles; mem_resp asserts the following cycle with mem_rdata = 0x0000.
  - miss_count = 1.
- After the above fill, sweep addresses 0x0002..0x000E, one per cycle:
  - mem_resp = 1 every cycle; mem_rdata = 0x0001..0x0007.
  - No pmem_read; hit_count increments by 7.
- Conflict: fetch 0x0000, then 0x0080 (same index 0, new tag), then 0x0000 again:
  - Three fills, miss_count = 3.
  - Each returns its own line's word 0.
- Assert rst_n low two cycles into a fill of 0x0130:
  - pmem_read drops without waiting for a clock edge.
  - After release, fetching 0x0130 misses again (miss_count = 1 counting from the reset); a stray pmem_resp in IDLE causes no array write.
- Abandoned request: during a fill of 0x0040, change mem_address to 0x0050 and deassert mem_read:
  - The line for 0x0040 is installed with no mem_resp.
  - A later read of 0x0040 hits immediately.
- SAT_CNT = 1: force more than 65535 hits -> hit_count holds at 0xFFFF. SAT_CNT = 0: hit_count wraps to 0x0000.
